dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-cache port; answers the requests the core issues on dcache_addr/dcache_we/dcache_re/dcache_din.
- Returns dcache_dout and drives stall back to the core.
- Word-addressed synchronous RAM with per-byte write enables and a programmable access latency.
- Used as the simulation and FPGA backing store behind the core, and as the stall source for pipeline-freeze testing.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two.
- AW, 12, word-address width; log2(DEPTH).
- LATENCY, 1, cycles from request acceptance to data/commit; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clk.
- dcache_addr  input  32  byte address; word index = dcache_addr[AW+1:2]; bits [1:0] and bits above AW+1 ignored.
- dcache_we  input  4  byte write enables; bit i writes byte i (din[8i+7:8i]).
- dcache_re  input  1  read request.
- dcache_din  input  32  write data.
- dcache_dout  output  32  read data, registered.
- stall  output  1  registered; 1 = responder busy, core must hold all request inputs stable.
- access_count  output  32  number of completed accesses, wrapping.

Behaviour:
- Request: a cycle with dcache_re=1 or dcache_we!=0.
- Requests are sampled only in IDLE.
- Reset (reset=0 at an edge):
  - state=IDLE, stall=0, dcache_dout=0, access_count=0, latency counter=0.
  - RAM contents are not cleared.
  - Reset mid-BUSY discards the pending access; a pending write is never committed.
- States: IDLE, BUSY.
- IDLE, request seen at an edge:
  - Latch word index, we, re, din.
  - LATENCY=1: complete at this same edge and stay in IDLE; stall stays 0.
  - LATENCY>1: go to BUSY; load counter with LATENCY-2; stall=1 from the next cycle.
- BUSY:
  - Inputs are ignored.
  - At each edge with counter!=0: counter decrements.
  - At the edge with counter=0: complete, state=IDLE, stall=0.
  - Total stall-high cycles = LATENCY-1.
- Completion, all in the same edge:
  - If latched re: dcache_dout <= RAM[idx] (old contents).
  - For each latched we[i]: RAM[idx] byte i <= din byte i.
  - access_count += 1.
- Simultaneous re and we: the write commits and dcache_dout returns the pre-write word (read-before-write).
- dcache_dout holds its value until the next completed read; writes-only completions leave it unchanged.
- No request in IDLE: nothing changes.
- Back-to-back requests with LATENCY=1: one completion per cycle, never stalls.
- With LATENCY>1, the edge that completes a BUSY access does not accept a new request. The earliest next acceptance is the following edge, where the core's (possibly new) request is sampled in IDLE.
- Address wrap: word index DEPTH-1 +1 → 0. Addresses differing only above bit AW+1 alias the same word.
- access_count wraps 0xFFFFFFFF → 0.
- Misaligned byte offsets are not realigned; the core supplies pre-shifted data and byte enables.

Test Plan:
- Reset: hold reset=0 for 2 cycles with re=1 → stall=0, dcache_dout=0, access_count=0. After release, a previously written word is still readable.
- LATENCY=1 write/read:
  - Write addr 0x10, we=4'b1111, din=0xDEADBEEF.
  - Next cycle re addr 0x10 → dcache_dout=0xDEADBEEF one edge later; stall never 1; access_count=2.
- Byte enables: mem[0x20]=0x11223344, then write we=4'b0101 din=0xAABBCCDD → readback 0x11BB33DD.
- LATENCY=4 read:
  - Request at edge 0 → stall=1 for exactly 3 cycles.
  - dcache_dout updates at edge 3; input changes during stall do not alter the access.
- Read+write same cycle: mem[0x30]=0x01, re=1, we=4'hF, din=0x02 → dcache_dout=0x01; a subsequent read returns 0x02.
- Reset mid-BUSY (LATENCY=4): write 0x55 to 0x40, assert reset at edge 1 → stall=0 next cycle; a later read of 0x40 returns its old value. Separately, an access to addr (DEPTH*4)+0x40 aliases 0x40.

Source files
------------

// File: rtl/dmem_if.sv
// Data-cache request/response bundle between the core (master) and the
// backing-store responder (slave).
//   dcache_addr  : byte address of the request
//   dcache_we    : per-byte write enables
//   dcache_re    : read request
//   dcache_din   : write data
//   dcache_dout  : registered read data
//   stall        : responder busy, core holds its request stable
//   access_count : completed accesses, wrapping
interface dmem_if;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic [31:0] access_count;

  modport master (
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    input  dcache_dout, stall, access_count
  );

  modport slave (
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    output dcache_dout, stall, access_count
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed synchronous RAM answering the core's data-cache port, with
// per-byte write enables and a programmable access latency that is reported
// to the core through a registered stall.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : dmem_if slave (request in, dout/stall/access_count out)
module dmem_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned AW      = 12,
  parameter int unsigned LATENCY = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int unsigned CW = 4;
  // Counter preload; BUSY lasts LOAD+1 edges so stall is high LATENCY-1 cycles.
  localparam logic [CW-1:0] LOAD   = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam bit            SINGLE = (LATENCY == 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  // Request captured at acceptance; the bus is ignored while BUSY.
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_we;
  logic            r_re;
  logic [31:0]     r_din;

  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_dout;
  logic [31:0]     r_count;
  logic            r_stall;

  logic [AW-1:0]   w_idx;
  logic            w_req;
  logic            w_accept;
  logic            w_complete;
  logic [AW-1:0]   w_c_idx;
  logic [3:0]      w_c_we;
  logic            w_c_re;
  logic [31:0]     w_c_din;
  logic            w_unused;

  assign w_idx    = bus.dcache_addr[AW+1:2];
  assign w_req    = bus.dcache_re | (|bus.dcache_we);
  // Byte offset and high address bits never select a word.
  assign w_unused = ^{bus.dcache_addr[31:AW+2], bus.dcache_addr[1:0]};

  // Next state, completion strobe and the operands the completion uses.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_c_idx     = r_idx;
    w_c_we      = r_we;
    w_c_re      = r_re;
    w_c_din     = r_din;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (SINGLE) begin
            // Single-cycle latency completes straight from the bus.
            w_complete = 1'b1;
            w_c_idx    = w_idx;
            w_c_we     = bus.dcache_we;
            w_c_re     = bus.dcache_re;
            w_c_din    = bus.dcache_din;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = LOAD;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state, captured request, read data and access counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_dout  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_we    <= '0;
      r_re    <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stall <= (w_state_nxt == S_BUSY);
      if (w_accept) begin
        r_idx <= w_idx;
        r_we  <= bus.dcache_we;
        r_re  <= bus.dcache_re;
        r_din <= bus.dcache_din;
      end
      if (w_complete) begin
        r_count <= r_count + 32'd1;
        // Sampled before this edge's write lands: read-before-write.
        if (w_c_re) r_dout <= r_mem[w_c_idx];
      end
    end
  end

  // RAM has no reset; a reset edge suppresses the pending commit.
  always_ff @(posedge clk) begin
    if (reset && w_complete) begin
      if (w_c_we[0]) r_mem[w_c_idx][7:0]   <= w_c_din[7:0];
      if (w_c_we[1]) r_mem[w_c_idx][15:8]  <= w_c_din[15:8];
      if (w_c_we[2]) r_mem[w_c_idx][23:16] <= w_c_din[23:16];
      if (w_c_we[3]) r_mem[w_c_idx][31:24] <= w_c_din[31:24];
    end
  end

  assign bus.dcache_dout  = r_dout;
  assign bus.stall        = r_stall;
  assign bus.access_count = r_count;

endmodule
